// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB) with retire counter and trap
// Ports: clk, rst_n (async active-low); opcode/mem_ready/branch_taken in; memory strobes (mem_req, mem_we,
// addr_sel, ir_load), PC control (pc_write, pc_src), datapath selects (imm_fmt, alu_a_sel, alu_b_sel, wb_sel),
// reg_write, trap/trap_cause and the instret counter out.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       imm_fmt,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic             trap_cause,
    output logic [CNT_W-1:0] instret
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(MEM_TIMEOUT - 1);
    typedef enum logic [2:0] {
        START  = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;
    state_t state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic cause_nx;
    logic is_load, is_opimm, is_op, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, legal;
    logic [2:0] fmt;
    assign is_load   = opcode == 7'b0000011;
    assign is_opimm  = opcode == 7'b0010011;
    assign is_op     = opcode == 7'b0110011;
    assign is_store  = opcode == 7'b0100011;
    assign is_branch = opcode == 7'b1100011;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign fmt = (is_load | is_opimm | is_jalr) ? 3'd1 :
                 is_store                       ? 3'd2 :
                 is_branch                      ? 3'd3 :
                 (is_lui | is_auipc)            ? 3'd4 :
                 is_jal                         ? 3'd5 : 3'd0;
    // OP is the only legal opcode without an immediate
    assign legal = (fmt != 3'd0) | is_op;
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        imm_fmt   = 3'd0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        trap      = state == TRAP;
        state_nx  = state;
        tcnt_nx   = '0;
        cause_nx  = trap_cause;
        case (state)
            START: state_nx = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                if (mem_ready) state_nx = DECODE;
                else if (tcnt == TLIM) begin
                    state_nx = TRAP;
                    cause_nx = 1'b1;
                end else tcnt_nx = tcnt + 1'b1;
            end
            DECODE: begin
                imm_fmt  = fmt;
                state_nx = legal ? EXEC : TRAP;
                cause_nx = 1'b0;
            end
            EXEC: begin
                imm_fmt   = fmt;
                alu_a_sel = (is_auipc | is_branch | is_jal) ? 2'd1 : is_lui ? 2'd2 : 2'd0;
                alu_b_sel = !is_op;
                pc_write  = is_branch;
                pc_src    = {1'b0, is_branch & branch_taken};
                state_nx  = is_branch ? FETCH : (is_load | is_store) ? MEM : WB;
            end
            MEM: begin
                imm_fmt  = fmt;
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                pc_write = mem_ready & is_store;
                if (mem_ready) state_nx = is_store ? FETCH : WB;
                else if (tcnt == TLIM) begin
                    state_nx = TRAP;
                    cause_nx = 1'b1;
                end else tcnt_nx = tcnt + 1'b1;
            end
            WB: begin
                imm_fmt   = fmt;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_sel    = is_load ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
                pc_src    = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                state_nx  = FETCH;
            end
            default: ;
        endcase
    end
    // every retirement point (branch EXEC, store MEM completion, WB) is exactly where pc_write fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= START;
            tcnt       <= '0;
            trap_cause <= 1'b0;
            instret    <= '0;
        end else begin
            state      <= state_nx;
            tcnt       <= tcnt_nx;
            trap_cause <= cause_nx;
            instret    <= instret + CNT_W'(pc_write);
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized self-checking bench for multicycle_ctrl_fsm against a per-instruction cycle model
module tb_multicycle_ctrl_fsm;
    localparam int TO = 4;
    localparam int CW = 8;
    localparam logic [6:0] LD = 7'b0000011, OPI = 7'b0010011, OPR = 7'b0110011, ST = 7'b0100011,
                           BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111,
                           AUIPC = 7'b0010111, ILL = 7'b0111000;
    typedef struct packed {
        logic       req, we, asel, irl, pcw;
        logic [1:0] pcs;
        logic [2:0] imm;
        logic [1:0] alua;
        logic       alub, rw;
        logic [1:0] wbs;
        logic       trap;
    } outs_t;
    logic clk = 1'b0, rst_n, mem_ready, branch_taken;
    logic [6:0] opcode;
    logic mem_req, mem_we, addr_sel, ir_load, pc_write, alu_b_sel, reg_write, trap, trap_cause;
    logic [1:0] pc_src, alu_a_sel, wb_sel;
    logic [2:0] imm_fmt;
    logic [CW-1:0] instret;
    outs_t obs, e;
    int checks, errors, exp_ret;
    logic [6:0] ops [9] = '{LD, OPI, OPR, ST, BR, JAL, JALR, LUI, AUIPC};
    assign obs = {mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src, imm_fmt, alu_a_sel, alu_b_sel,
                  reg_write, wb_sel, trap};
    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load), .pc_write(pc_write),
        .pc_src(pc_src), .imm_fmt(imm_fmt), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        case (op)
            LD, OPI, JALR: return 3'd1;
            ST:            return 3'd2;
            BR:            return 3'd3;
            LUI, AUIPC:    return 3'd4;
            JAL:           return 3'd5;
            default:       return 3'd0;
        endcase
    endfunction
    // builds the expected per-cycle output table of one legal instruction, then drives and compares it
    task automatic run_instr(input logic [6:0] op, input logic tk, input int fw, input int mw, input string nm);
        outs_t q[$];
        bit r[$];
        outs_t x;
        int ex;
        for (int i = 0; i <= fw; i++) begin
            x = '0; x.req = 1'b1; x.irl = (i == fw);
            q.push_back(x); r.push_back(i == fw);
        end
        x = '0; x.imm = fmt_of(op);
        q.push_back(x); r.push_back(1'($urandom));
        ex = q.size();
        x = '0; x.imm = fmt_of(op);
        x.alua = (op == AUIPC || op == BR || op == JAL) ? 2'd1 : (op == LUI) ? 2'd2 : 2'd0;
        x.alub = op != OPR;
        if (op == BR) begin x.pcw = 1'b1; x.pcs = {1'b0, tk}; end
        q.push_back(x); r.push_back(1'($urandom));
        if (op == LD || op == ST)
            for (int i = 0; i <= mw; i++) begin
                x = '0; x.req = 1'b1; x.asel = 1'b1; x.we = op == ST; x.imm = fmt_of(op);
                x.pcw = (op == ST) && (i == mw);
                q.push_back(x); r.push_back(i == mw);
            end
        if (op != BR && op != ST) begin
            x = '0; x.imm = fmt_of(op); x.rw = 1'b1; x.pcw = 1'b1;
            x.wbs = (op == LD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
            x.pcs = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
            q.push_back(x); r.push_back(1'($urandom));
        end
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            mem_ready = r[k];
            opcode = op;
            branch_taken = (k == ex) ? tk : 1'($urandom);
            #1;
            checks++;
            if (obs !== q[k]) begin
                errors++;
                $display("FAIL %s cyc%0d outputs: got %h want %h", nm, k, obs, q[k]);
            end
            checks++;
            if (instret !== CW'(exp_ret)) begin
                errors++;
                $display("FAIL %s cyc%0d instret: got %0d want %0d", nm, k, instret, CW'(exp_ret));
            end
            if (q[k].pcw) exp_ret++;
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_ret = 0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = LD; branch_taken = 1'b1;
        #23;
        checks++;
        if (obs !== '0 || instret !== '0 || trap_cause !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %h/%0d/%b want 0/0/0", obs, instret, trap_cause);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 0;
        #1;
        checks++;
        if (obs !== '0 || instret !== '0) begin
            errors++;
            $display("FAIL reset_start: got %h/%0d want 0/0", obs, instret);
        end
    endtask
    task automatic test_op();
        run_instr(OPR, 1'b0, 0, 0, "op");
        #5;
        checks++;
        if (instret !== 8'd1) begin errors++; $display("FAIL op_instret: got %0d want 1", instret); end
    endtask
    task automatic test_load_wait();
        do_reset();
        run_instr(LD, 1'b0, 0, 3, "load_wait");
        #5;
        checks++;
        if (instret !== 8'd1) begin errors++; $display("FAIL load_instret: got %0d want 1", instret); end
    endtask
    task automatic test_branch();
        do_reset();
        run_instr(BR, 1'b1, 0, 0, "branch_taken");
        run_instr(BR, 1'b0, 0, 0, "branch_not");
        #5;
        checks++;
        if (instret !== 8'd2) begin errors++; $display("FAIL branch_instret: got %0d want 2", instret); end
    endtask
    task automatic test_jumps();
        do_reset();
        run_instr(JAL, 1'b0, 0, 0, "jal");
        run_instr(JALR, 1'b0, 0, 0, "jalr");
        #5;
        checks++;
        if (instret !== 8'd2) begin errors++; $display("FAIL jump_instret: got %0d want 2", instret); end
    endtask
    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(0, 8)], 1'($urandom), int'($urandom_range(0, TO - 1)),
                      int'($urandom_range(0, TO - 1)), "random");
        #5;
        checks++;
        if (instret !== CW'(exp_ret)) begin
            errors++;
            $display("FAIL random_instret: got %0d want %0d", instret, CW'(exp_ret));
        end
    endtask
    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 256; n++) run_instr(BR, 1'($urandom), 0, 0, "wrap");
        #5;
        checks++;
        if (instret !== 8'd0) begin errors++; $display("FAIL wrap_instret: got %0d want 0", instret); end
    endtask
    task automatic test_illegal();
        do_reset();
        run_instr(OPR, 1'b0, 0, 0, "ill_pre");
        opcode = ILL;
        @(negedge clk); mem_ready = 1'b1; #1;
        e = '0; e.req = 1'b1; e.irl = 1'b1;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL ill_fetch: got %h want %h", obs, e); end
        @(negedge clk); #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL ill_decode: got %h want 0", obs); end
        e = '0; e.trap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom); branch_taken = 1'($urandom); opcode = ops[$urandom_range(0, 8)];
            #1;
            checks++;
            if (obs !== e || trap_cause !== 1'b0 || instret !== 8'd1) begin
                errors++;
                $display("FAIL ill_trap%0d: got %h/%b/%0d want %h/0/1", i, obs, trap_cause, instret, e);
            end
        end
    endtask
    task automatic test_timeout();
        do_reset();
        run_instr(OPR, 1'b0, 0, 0, "to_pre");
        e = '0; e.req = 1'b1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL to_fetch%0d: got %h want %h", i, obs, e); end
        end
        e = '0; e.trap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ready = 1'($urandom); #1;
            checks++;
            if (obs !== e || trap_cause !== 1'b1 || instret !== 8'd1) begin
                errors++;
                $display("FAIL to_trap%0d: got %h/%b/%0d want %h/1/1", i, obs, trap_cause, instret, e);
            end
        end
    endtask
    task automatic test_reset_mid_mem();
        do_reset();
        run_instr(OPR, 1'b0, 0, 0, "rm_pre");
        opcode = LD;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0; #1;
        e = '0; e.req = 1'b1; e.asel = 1'b1; e.imm = 3'd1;
        checks++;
        if (obs !== e || instret !== 8'd1) begin
            errors++;
            $display("FAIL rm_mem: got %h/%0d want %h/1", obs, instret, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || instret !== 8'd0) begin
            errors++;
            $display("FAIL rm_reset: got %h/%0d want 0/0", obs, instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        checks = 0; errors = 0; exp_ret = 0;
        test_reset();
        test_op();
        test_load_wait();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
